// File: rtl/rt_cross_clk_pkg.sv
// Shared types and constants for the toggle request/acknowledge clock-domain crossing.
package rt_cross_clk_pkg;

    typedef enum logic {
        RT_ST_IDLE  = 1'b0,
        RT_ST_VALID = 1'b1
    } rt_rsp_state_t;

    localparam int RT_SYNC_STAGES_DEF = 2;

endpackage : rt_cross_clk_pkg

// File: rtl/rt_sync_bit.sv
// N-flop single-bit synchroniser, synchronous active-low reset to 0.
// Shared by both ends of the crossing (request path here, ack path at the sender).
module rt_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : rt_sync_bit

// File: rtl/rt_cross_clk_rsp.sv
// Receive side of a two-phase req/ack crossing: captures the sender's held word,
// offers it on valid/ready and returns the ack toggle only once it is consumed.
module rt_cross_clk_rsp
    import rt_cross_clk_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int SYNC_STAGES = RT_SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 rt_i_bclk,
    input  logic                 rt_i_rstn_bclk,
    input  logic                 rt_i_req_tog,
    input  logic [DWIDTH-1:0]    rt_i_din,
    output logic                 rt_o_ack_tog,
    output logic                 rt_o_valid_bclk,
    output logic [DWIDTH-1:0]    rt_o_dout_bclk,
    input  logic                 rt_i_ready_bclk,
    output logic                 rt_o_busy_bclk,
    output logic [CNT_WIDTH-1:0] rt_o_xfer_cnt_bclk,
    output logic                 rt_o_err_bclk
);

    rt_rsp_state_t        r_state;
    logic                 r_ack_tog;
    logic                 r_valid;
    logic [DWIDTH-1:0]    r_dout;
    logic [CNT_WIDTH-1:0] r_xfer_cnt;
    logic                 r_err;
    logic                 w_req_s;
    logic                 w_pending;

    rt_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk  (rt_i_bclk),
        .i_rstn (rt_i_rstn_bclk),
        .i_d    (rt_i_req_tog),
        .o_q    (w_req_s)
    );

    // Level compare: an outstanding request exists whenever the toggles disagree.
    assign w_pending = w_req_s ^ r_ack_tog;

    always_ff @(posedge rt_i_bclk) begin
        if (!rt_i_rstn_bclk) begin
            r_state    <= RT_ST_IDLE;
            r_ack_tog  <= 1'b0;
            r_valid    <= 1'b0;
            r_dout     <= '0;
            r_xfer_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                RT_ST_IDLE: begin
                    if (w_pending) begin
                        r_dout  <= rt_i_din;
                        r_valid <= 1'b1;
                        r_state <= RT_ST_VALID;
                    end
                end
                RT_ST_VALID: begin
                    // Toggles agreeing while a word is held means the sender re-toggled early.
                    if (w_req_s == r_ack_tog) begin
                        r_err <= 1'b1;
                    end
                    if (rt_i_ready_bclk) begin
                        r_valid    <= 1'b0;
                        r_ack_tog  <= ~r_ack_tog;
                        r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
                        r_state    <= RT_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= RT_ST_IDLE;
                end
            endcase
        end
    end

    assign rt_o_ack_tog       = r_ack_tog;
    assign rt_o_valid_bclk    = r_valid;
    assign rt_o_dout_bclk     = r_dout;
    assign rt_o_busy_bclk     = (r_state == RT_ST_VALID);
    assign rt_o_xfer_cnt_bclk = r_xfer_cnt;
    assign rt_o_err_bclk      = r_err;

endmodule : rt_cross_clk_rsp

// File: tb/tb_rt_cross_clk_rsp.sv
// Directed + randomized bench for rt_cross_clk_rsp with a transaction-level sender model.
module tb_rt_cross_clk_rsp;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req;
    logic [DW-1:0] din;
    logic          ack;
    logic          valid;
    logic [DW-1:0] dout;
    logic          ready;
    logic          busy;
    logic [CW-1:0] cnt;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model: ack parity and count follow the number of completed transfers.
    int   m_xfers = 0;
    bit   m_err   = 1'b0;
    logic m_req   = 1'b0;

    rt_cross_clk_rsp #(
        .DWIDTH      (DW),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (CW)
    ) dut (
        .rt_i_bclk          (clk),
        .rt_i_rstn_bclk     (rstn),
        .rt_i_req_tog       (req),
        .rt_i_din           (din),
        .rt_o_ack_tog       (ack),
        .rt_o_valid_bclk    (valid),
        .rt_o_dout_bclk     (dout),
        .rt_i_ready_bclk    (ready),
        .rt_o_busy_bclk     (busy),
        .rt_o_xfer_cnt_bclk (cnt),
        .rt_o_err_bclk      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ack();
        return 32'(m_xfers % 2);
    endfunction

    function automatic logic [31:0] exp_cnt();
        return 32'(m_xfers % (1 << CW));
    endfunction

    task automatic do_xfer(input logic [DW-1:0] d, input int hold, input bit inj);
        din   = d;
        m_req = ~m_req;
        req   = m_req;
        for (int i = 1; i <= SS + 1; i++) begin
            ready = 1'($urandom);
            tick();
            check("latency_valid", 32'(valid), 32'(i == SS + 1));
        end
        check("capture_dout", 32'(dout), 32'(d));
        check("busy_in_valid", 32'(busy), 32'd1);
        check("ack_before_hs", 32'(ack), exp_ack());
        ready = (hold == 0);
        for (int j = 1; j <= hold; j++) begin
            if (inj && (j == 2 || j == 4)) begin
                m_req = ~m_req;
                req   = m_req;
            end
            tick();
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_dout", 32'(dout), 32'(d));
            check("bp_ack", 32'(ack), exp_ack());
        end
        if (inj) begin
            m_err = 1'b1;
            check("err_set", 32'(err), 32'd1);
        end
        ready = 1'b1;
        tick();
        m_xfers++;
        check("hs_valid_fall", 32'(valid), 32'd0);
        check("hs_ack", 32'(ack), exp_ack());
        check("hs_cnt", 32'(cnt), exp_cnt());
        check("hs_err", 32'(err), 32'(m_err));
        check("hs_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 2; k++) begin
            ready = 1'($urandom);
            din   = DW'($urandom);
            tick();
            check("no_extra_word", 32'(valid), 32'd0);
        end
    endtask

    initial begin
        rstn  = 1'b0;
        req   = 1'b0;
        din   = '0;
        ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            req   = 1'($urandom);
            din   = DW'($urandom);
            ready = 1'($urandom);
            tick();
        end
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req  = 1'b0;
        rstn = 1'b1;
        tick();
        check("post_rst_valid", 32'(valid), 32'd0);

        // Single transfer, ready high
        do_xfer(8'hA5, 0, 1'b0);

        // Back-pressure
        do_xfer(8'h3C, 10, 1'b0);

        // Protocol error: sender toggles twice while a word is held
        do_xfer(DW'($urandom), 10, 1'b1);

        // Counter wrap with random data and random hold
        for (int n = 0; n < 17; n++) begin
            do_xfer(DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset mid-transfer
        din   = DW'($urandom);
        m_req = ~m_req;
        req   = m_req;
        ready = 1'b0;
        for (int i = 0; i < SS + 1; i++) tick();
        check("mid_valid_up", 32'(valid), 32'd1);
        rstn  = 1'b0;
        m_req = 1'b0;
        req   = 1'b0;
        tick();
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rstn    = 1'b1;
        m_xfers = 0;
        m_err   = 1'b0;
        tick();
        check("after_rst_valid", 32'(valid), 32'd0);
        do_xfer(DW'($urandom), 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rt_cross_clk_rsp
